playbus_block_sequencer: RTL and testbench
==========================================

// Module: playbus_block_sequencer
// PURPOSE
//  Upstream command stage for the PlayBus controller: drives its FUNC, ADD and GO inputs.
//  Applies one function across an address range FIRST_ADD..LAST_ADD, one address per operation.
//  Dynamic functions (3-7): asserts GO, waits for St==3 (end_dynamic), drops GO, waits St==0, advances.
//  Static functions (0-2): holds each address DWELL cycles with GO low (display sweep). Clocked on the PlayBus clock.
// PARAMETERS
//  ADD_W    4  address width; matches PlayBus ADD
//  DWELL    2  cycles each address is held for static functions (>=1)
//  TIMEOUT  6  max cycles waiting on any St condition before ERROR (>=4)
// PORTS
//  CK2HZ      in   1      system clock (shared with PlayBus)
//  n_CLR      in   1      reset; synchronous, active-low
//  RUN        in   1      start request, level; rising edge starts a block
//  STOP       in   1      level; ends block after current operation completes
//  FUNC_SEL   in   3      function to apply, sampled at start
//  FIRST_ADD  in   ADD_W  first address, sampled at start
//  LAST_ADD   in   ADD_W  last address, sampled at start
//  St         in   2      PlayBus state (0 idle,1 start,2 write,3 end)
//  GO         out  1      to PlayBus GO, registered
//  FUNC       out  3      to PlayBus FUNC, registered
//  ADD        out  ADD_W  to PlayBus ADD, registered
//  BUSY       out  1      high in any state except IDLE/DONE/ERROR
//  DONE       out  1      block complete; held until next start or reset
//  ERR        out  1      timeout; held until next start or reset
// BEHAVIOUR
//  - Reset (n_CLR low at edge): state IDLE; GO=0, FUNC=0, ADD=0, BUSY=0, DONE=0, ERR=0; RUN edge reg=0, counters=0.
//  - RUN edge: registered RUN_q; start = RUN & ~RUN_q, taken only in IDLE/DONE/ERROR; ignored while BUSY.
//  - Outputs are registered; FUNC/ADD change only when St==0 and GO==0 (PlayBus decodes FUNC in every state).
//  - States:
//    IDLE:    start -> LOAD; clear DONE/ERR.
//    LOAD:    FUNC<=FUNC_SEL, ADD<=FIRST_ADD, latch LAST_ADD into last_q; -> ISSUE if FUNC_SEL>=3 else HOLD.
//    ISSUE:   GO=1; St==3 -> RELEASE (GO drops next edge).
//    RELEASE: GO=0; St==0 -> NEXT.
//    HOLD:    GO=0; count DWELL cycles -> NEXT.
//    NEXT:    STOP or ADD==last_q -> DONE; else ADD<=ADD+1 mod 2^ADD_W -> ISSUE/HOLD per FUNC.
//    DONE:    DONE=1, GO=0, FUNC/ADD hold last values; start -> LOAD.
//    ERROR:   ERR=1, GO=0; start -> LOAD.
//  - Latency: start edge at cycle n -> LOAD n+1 -> GO=1 visible after edge n+2.
//  - Timeout: cycle counter reset on entry to ISSUE/RELEASE; reaching TIMEOUT in either -> ERROR.
//  - FIRST_ADD>LAST_ADD: increments wrap 2^ADD_W-1 -> 0 until ADD==last_q. FIRST==LAST: exactly one operation.
//  - STOP mid-operation: never drop GO before St==3; current transfer completes, then DONE at NEXT.
//  - STOP and start in same cycle: STOP wins, start ignored.
//  - FUNC_SEL/FIRST_ADD/LAST_ADD changes after LOAD: no effect until next start.
//  - Reset mid-operation: reset values at next edge regardless of St; PlayBus cleared by its own n_CLR.
// CONFIGURATION
//  PLAYBUS_AUTO_REPEAT_EN defined: NEXT at ADD==last_q (no STOP) reloads ADD<=FIRST_ADD (sampled value),
//    repeats until STOP; DONE only via STOP.
//  Undefined: block runs once, then DONE.
// TESTING
//  Bench models PlayBus St from GO (0->1->2->3, hold 3 while GO, 3->0 when GO low).
//  1 FUNC_SEL=4, FIRST=2, LAST=5, RUN pulse -> 4 GO pulses at ADD 2,3,4,5; FUNC=4 throughout; DONE=1, BUSY=0.
//  2 FUNC_SEL=0, FIRST=14, LAST=1, DWELL=2 -> ADD 14,15,0,1 each held 2 cycles, GO never high, DONE=1.
//  3 FUNC_SEL=3, FIRST=LAST=7 -> exactly one GO pulse at ADD=7; second RUN edge while BUSY ignored.
//  4 St stuck at 1 after GO -> ERR=1 after 6 cycles in ISSUE, GO=0; new RUN edge clears ERR and restarts.
//  5 STOP raised while St==2 at ADD=3 (range 0..9) -> GO held until St==3, no ADD=4 op, DONE=1.
//  6 n_CLR low mid-ISSUE -> next edge GO=0, ADD=0, FUNC=0, BUSY=0; with AUTO_REPEAT_EN, range 1..2 loops 1,2,1,2 until STOP.

Source files
------------

// File: rtl/playbus_block_sequencer_if.sv
// Bundle of the signals passed between the block sequencer and its environment.
// The environment is the command source plus the PlayBus controller.
//   master : sequencer side.
//            Inputs:  RUN, STOP, FUNC_SEL, FIRST_ADD, LAST_ADD, St.
//            Outputs: GO, FUNC, ADD, BUSY, DONE, ERR.
//   slave  : environment side, with every direction reversed.
// ADD_W must match the ADD_W of the sequencer that uses this interface.
interface playbus_block_sequencer_if #(
  parameter int ADD_W = 4
);
  logic             RUN;
  logic             STOP;
  logic [2:0]       FUNC_SEL;
  logic [ADD_W-1:0] FIRST_ADD;
  logic [ADD_W-1:0] LAST_ADD;
  logic [1:0]       St;
  logic             GO;
  logic [2:0]       FUNC;
  logic [ADD_W-1:0] ADD;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    input  RUN, STOP, FUNC_SEL, FIRST_ADD, LAST_ADD, St,
    output GO, FUNC, ADD, BUSY, DONE, ERR
  );

  modport slave (
    output RUN, STOP, FUNC_SEL, FIRST_ADD, LAST_ADD, St,
    input  GO, FUNC, ADD, BUSY, DONE, ERR
  );
endinterface

// File: rtl/playbus_block_sequencer.sv
// playbus_block_sequencer
// This is the upstream command stage for the PlayBus controller. It applies one
// function across the address range FIRST_ADD..LAST_ADD, one address per
// operation, and the range wraps modulo 2^ADD_W.
//   Dynamic functions (3-7): raise GO, wait for St==3, drop GO, wait for St==0,
//   then advance to the next address.
//   Static functions (0-2): GO stays low and each address is held for DWELL
//   cycles, which gives a display sweep.
// Ports:
//   CK2HZ : clock shared with PlayBus.
//   n_CLR : synchronous, active-low reset.
//   pb    : playbus_block_sequencer_if.master.
//           Inputs:  RUN, STOP, FUNC_SEL, FIRST_ADD, LAST_ADD, St.
//           Outputs: GO, FUNC, ADD, BUSY, DONE, ERR. All outputs are registered.
// Configuration macro: PLAYBUS_AUTO_REPEAT_EN.
//   Defined: the range repeats from FIRST_ADD until STOP, and DONE is reached
//   only through STOP.
//   Undefined: the range runs once, then DONE.
module playbus_block_sequencer #(
  parameter int ADD_W   = 4,
  parameter int DWELL   = 2,
  parameter int TIMEOUT = 6
) (
  input logic                   CK2HZ,
  input logic                   n_CLR,
  playbus_block_sequencer_if.master pb
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_RELEASE, S_HOLD, S_NEXT, S_DONE, S_ERROR
  } state_t;

  localparam int CNT_MAX = (TIMEOUT > DWELL) ? TIMEOUT : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  // The NEXT cycle shows the current address too. HOLD therefore lasts
  // DWELL-1 cycles, so that each address is visible for exactly DWELL cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((DWELL > 1) ? DWELL - 2 : 0);

  state_t           state_q;
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ADD_W-1:0] last_q;
  logic             go_q, busy_q, done_q, err_q;
  logic [2:0]       func_q;
  logic [ADD_W-1:0] add_q;
`ifdef PLAYBUS_AUTO_REPEAT_EN
  logic [ADD_W-1:0] first_q;
`endif

  logic             start;
  logic             finish_d;
  logic [ADD_W-1:0] add_d;

  // When STOP and a RUN edge arrive in the same cycle, STOP wins and the start is dropped.
  assign start = pb.RUN & ~run_q & ~pb.STOP;

  always_comb begin
    finish_d = 1'b0;
    add_d    = add_q + ADD_W'(1);
`ifdef PLAYBUS_AUTO_REPEAT_EN
    finish_d = pb.STOP;
    if (add_q == last_q) add_d = first_q;
`else
    finish_d = pb.STOP | (add_q == last_q);
`endif
  end

  // Choose the per-address state. With DWELL==1, HOLD is skipped and the
  // sequencer goes straight to NEXT.
  function automatic state_t op_state(input logic [2:0] f);
    if (f >= 3'd3)     return S_ISSUE;
    else if (DWELL > 1) return S_HOLD;
    else                return S_NEXT;
  endfunction

  always_ff @(posedge CK2HZ) begin
    if (!n_CLR) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      func_q  <= '0;
      add_q   <= '0;
`ifdef PLAYBUS_AUTO_REPEAT_EN
      first_q <= '0;
`endif
    end else begin
      run_q <= pb.RUN;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          func_q  <= pb.FUNC_SEL;
          add_q   <= pb.FIRST_ADD;
          last_q  <= pb.LAST_ADD;
`ifdef PLAYBUS_AUTO_REPEAT_EN
          first_q <= pb.FIRST_ADD;
`endif
          cnt_q   <= '0;
          go_q    <= (pb.FUNC_SEL >= 3'd3);
          state_q <= op_state(pb.FUNC_SEL);
        end
        S_ISSUE, S_RELEASE: begin
          // In ISSUE, GO is held until end_dynamic, even when STOP is raised.
          if ((state_q == S_ISSUE && pb.St == 2'd3) ||
              (state_q == S_RELEASE && pb.St == 2'd0)) begin
            go_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= (state_q == S_ISSUE) ? S_RELEASE : S_NEXT;
          end else if (cnt_q == TO_LAST) begin
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) state_q <= S_NEXT;
          else                    cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_NEXT: begin
          if (finish_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            add_q   <= add_d;
            cnt_q   <= '0;
            go_q    <= (func_q >= 3'd3);
            state_q <= op_state(func_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pb.GO   = go_q;
  assign pb.FUNC = func_q;
  assign pb.ADD  = add_q;
  assign pb.BUSY = busy_q;
  assign pb.DONE = done_q;
  assign pb.ERR  = err_q;

endmodule

// File: tb/tb_playbus_block_sequencer.sv
// Directed bench for playbus_block_sequencer.
// It contains a small PlayBus St model: 0->1 on GO, then 1->2->3, St holds 3
// while GO is high, and returns to 0 once GO drops.
module tb_playbus_block_sequencer;
  logic CK2HZ = 1'b0;
  logic n_CLR = 1'b0;
  logic stuck = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  playbus_block_sequencer_if #(.ADD_W(4)) bus ();

  playbus_block_sequencer #(.ADD_W(4), .DWELL(2), .TIMEOUT(6)) dut (
    .CK2HZ (CK2HZ),
    .n_CLR (n_CLR),
    .pb    (bus)
  );

  always #5 CK2HZ = ~CK2HZ;

  always_ff @(posedge CK2HZ) begin
    if (!n_CLR) bus.St <= 2'd0;
    else begin
      case (bus.St)
        2'd0: if (bus.GO) bus.St <= 2'd1;
        2'd1: if (!stuck) bus.St <= 2'd2;
        2'd2: bus.St <= 2'd3;
        default: if (!bus.GO) bus.St <= 2'd0;
      endcase
    end
  end

  // Results of the most recent run_block call.
  logic [31:0] go_pack, add_pack;
  int go_n, add_n, go_cyc, first_go, end_cyc;
  logic busy_c1, err_c1, bad_func, bad_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [2:0] f, input logic [3:0] first, input logic [3:0] last);
    bus.FUNC_SEL  = f;
    bus.FIRST_ADD = first;
    bus.LAST_ADD  = last;
    bus.RUN       = 1'b1;
  endtask

  // Step one negedge at a time and log what the sequencer shows, until DONE,
  // ERR or the cycle budget. The task drops RUN at cycle 2 and can raise RUN
  // again at rerun_at. It raises STOP when ADD==stop_add while St==2, or once
  // stop_gos GO pulses have been seen.
  task automatic run_block(input int max_cyc, input logic [2:0] exp_func,
                           input int stop_add, input int rerun_at, input int stop_gos);
    int cyc = 0;
    logic go_prev = 1'b0;
    go_pack = '0; add_pack = '0; go_n = 0; add_n = 0; go_cyc = 0; first_go = -1;
    busy_c1 = 1'b0; err_c1 = 1'b0; bad_func = 1'b0; bad_drop = 1'b0;
    do begin
      @(negedge CK2HZ);
      cyc++;
      if (cyc == 1) begin busy_c1 = bus.BUSY; err_c1 = bus.ERR; end
      if (cyc == 2) bus.RUN = 1'b0;
      if (cyc == rerun_at) bus.RUN = 1'b1;
      if (bus.GO) begin
        go_cyc++;
        if (bus.FUNC !== exp_func) bad_func = 1'b1;
      end
      if (bus.GO && !go_prev) begin
        go_pack = {go_pack[27:0], bus.ADD};
        go_n++;
        if (first_go < 0) first_go = cyc;
      end
      if (go_prev && !bus.GO && bus.St !== 2'd3) bad_drop = 1'b1;
      if (bus.BUSY && cyc > 1) begin
        add_pack = {add_pack[27:0], bus.ADD};
        add_n++;
      end
      if (stop_add >= 0 && bus.GO && bus.ADD == 4'(stop_add) && bus.St == 2'd2) bus.STOP = 1'b1;
      if (stop_gos > 0 && go_n >= stop_gos) bus.STOP = 1'b1;
      go_prev = bus.GO;
    end while (!(bus.DONE || bus.ERR) && cyc < max_cyc);
    end_cyc = cyc;
  endtask

  initial begin
    bus.RUN = 1'b0; bus.STOP = 1'b0; bus.FUNC_SEL = '0; bus.FIRST_ADD = '0; bus.LAST_ADD = '0;
    repeat (2) @(negedge CK2HZ);
    check("rst_go",   bus.GO,   0);
    check("rst_func", bus.FUNC, 0);
    check("rst_add",  bus.ADD,  0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_err",  bus.ERR,  0);
    n_CLR = 1'b1;
    @(negedge CK2HZ);

    // Test 1: dynamic function 4 across addresses 2..5.
    start_block(3'd4, 4'd2, 4'd5);
    run_block(200, 3'd4, -1, 0, 0);
    check("t1_busy_load", busy_c1, 1);
    check("t1_first_go",  first_go, 2);
    check("t1_go_n",      go_n, 4);
    check("t1_go_adds",   go_pack, 32'h2345);
    check("t1_func",      bad_func, 0);
    check("t1_drop",      bad_drop, 0);
    check("t1_done",      bus.DONE, 1);
    check("t1_busy",      bus.BUSY, 0);
    check("t1_add_end",   bus.ADD, 5);
    check("t1_func_end",  bus.FUNC, 4);

    // Test 2: static sweep 14..1 that wraps; each address is held 2 cycles.
    start_block(3'd0, 4'd14, 4'd1);
    run_block(200, 3'd0, -1, 0, 0);
    check("t2_go_cyc",  go_cyc, 0);
    check("t2_add_n",   add_n, 8);
    check("t2_adds",    add_pack, 32'hEEFF0011);
    check("t2_done",    bus.DONE, 1);

    // Test 3: single address 7; a second RUN edge while BUSY is ignored.
    start_block(3'd3, 4'd7, 4'd7);
    run_block(200, 3'd3, -1, 4, 0);
    check("t3_go_n",   go_n, 1);
    check("t3_go_add", go_pack, 32'h7);
    check("t3_done",   bus.DONE, 1);
    repeat (3) @(negedge CK2HZ);
    check("t3_no_restart_busy", bus.BUSY, 0);
    check("t3_no_restart_done", bus.DONE, 1);
    bus.RUN = 1'b0;
    @(negedge CK2HZ);

    // Test 4: St stuck at 1 gives a timeout; a new RUN edge clears ERR.
    stuck = 1'b1;
    start_block(3'd3, 4'd5, 4'd5);
    run_block(200, 3'd3, -1, 0, 0);
    check("t4_issue_cyc", go_cyc, 6);
    check("t4_err_cyc",   end_cyc, 8);
    check("t4_err",       bus.ERR, 1);
    check("t4_go",        bus.GO, 0);
    check("t4_busy",      bus.BUSY, 0);
    check("t4_done",      bus.DONE, 0);
    stuck = 1'b0;
    repeat (4) @(negedge CK2HZ);
    start_block(3'd5, 4'd9, 4'd9);
    run_block(200, 3'd5, -1, 0, 0);
    check("t4_err_clr", err_c1, 0);
    check("t4_rerun",   go_pack, 32'h9);
    check("t4_redone",  bus.DONE, 1);

    // Test 5: STOP is raised at ADD=3 while St==2 (range 0..9).
    start_block(3'd6, 4'd0, 4'd9);
    run_block(300, 3'd6, 3, 0, 0);
    check("t5_go_n",  go_n, 4);
    check("t5_adds",  go_pack, 32'h0123);
    check("t5_drop",  bad_drop, 0);
    check("t5_done",  bus.DONE, 1);
    check("t5_add",   bus.ADD, 3);
    bus.STOP = 1'b0;
    @(negedge CK2HZ);

    // Test 6: reset in the middle of ISSUE.
    start_block(3'd4, 4'd6, 4'd9);
    begin
      int w = 0;
      do begin @(negedge CK2HZ); w++; if (w == 2) bus.RUN = 1'b0; end
      while (!(bus.GO && bus.St == 2'd1) && w < 20);
      check("t6_reached_issue", (bus.GO && bus.St == 2'd1), 1);
    end
    n_CLR = 1'b0;
    @(negedge CK2HZ);
    check("t6_go",   bus.GO, 0);
    check("t6_add",  bus.ADD, 0);
    check("t6_func", bus.FUNC, 0);
    check("t6_busy", bus.BUSY, 0);
    check("t6_done", bus.DONE, 0);
    n_CLR = 1'b1;
    @(negedge CK2HZ);

    // STOP and a RUN edge in the same cycle: the start is ignored.
    bus.STOP = 1'b1; bus.RUN = 1'b1;
    @(negedge CK2HZ);
    check("t7_busy_a", bus.BUSY, 0);
    @(negedge CK2HZ);
    check("t7_busy_b", bus.BUSY, 0);
    bus.STOP = 1'b0; bus.RUN = 1'b0;
    @(negedge CK2HZ);

    // Range 1..2 loops when auto-repeat is enabled; otherwise it runs once.
    start_block(3'd4, 4'd1, 4'd2);
`ifdef PLAYBUS_AUTO_REPEAT_EN
    run_block(300, 3'd4, -1, 0, 4);
    check("t8_go_n", go_n, 4);
    check("t8_adds", go_pack, 32'h1212);
`else
    run_block(300, 3'd4, -1, 0, 0);
    check("t8_go_n", go_n, 2);
    check("t8_adds", go_pack, 32'h12);
`endif
    check("t8_done", bus.DONE, 1);
    bus.STOP = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
